// File: rtl/alt_wb_merge.sv
// alt_wb_merge: merges results of a fixed-latency alternate pipe into a shared
// writeback slot. Announcements carry the tag; the data follows DATA_LAT cycles
// later, the pair is queued and drained whenever the primary slot is free.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   except              pipeline flush (drops in-flight tags and queued pairs)
//   alt_en/II/op/reg/wen  announcement (valid when alt_en != 0)
//   alt_data            result, present DATA_LAT cycles after its announcement
//   main_busy           primary writeback slot taken this cycle
//   wb_en/II/op/reg/wen/data  registered merged writeback, zero when idle
//   pause               registered back-pressure to the producer
//
// Build option: define ALT_WB_BYPASS_EN to let a pair skip the FIFO when the
// FIFO is empty and the slot is free (one cycle less latency).
module alt_wb_merge #(
  parameter int unsigned DATA_LAT   = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 136
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  except,
  input  logic [3:0]            alt_en,
  input  logic [9:0]            alt_II,
  input  logic [12:0]           alt_op,
  input  logic [8:0]            alt_reg,
  input  logic                  alt_wen,
  input  logic [DATA_WIDTH-1:0] alt_data,
  input  logic                  main_busy,
  output logic                  wb_en,
  output logic [9:0]            wb_II,
  output logic [12:0]           wb_op,
  output logic [8:0]            wb_reg,
  output logic                  wb_wen,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  pause
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned StgW = $clog2(DATA_LAT + 1);
  localparam int unsigned SumW = ((CntW > StgW) ? CntW : StgW) + 1;

  typedef struct packed {
    logic [9:0]  ii;
    logic [12:0] op;
    logic [8:0]  rd;
    logic        wen;
  } tagT;

  typedef struct packed {
    tagT                   tag;
    logic [DATA_WIDTH-1:0] data;
  } entryT;

  tagT                 tagPipe [DATA_LAT];
  logic [DATA_LAT-1:0] validPipe;
  entryT               fifoMem [DEPTH];
  logic [PtrW-1:0]     rdPtr;
  logic [PtrW-1:0]     wrPtr;
  logic [CntW-1:0]     count;

  tagT             annTag;
  logic            annValid;
  logic            pairValid;
  entryT           pair;
  entryT           head;
  logic            fifoEmpty;
  logic            fifoFull;
  logic            popFire;
  logic            bypassFire;
  logic            pushReq;
  logic            pushFire;
  logic [StgW-1:0] stageCnt;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    nextPtr = (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Announcement and pair formation; a tag announced during a flush is dropped.
  assign annTag    = '{ii: alt_II, op: alt_op, rd: alt_reg, wen: alt_wen};
  assign annValid  = (alt_en != 4'd0) && !except;
  assign pairValid = validPipe[DATA_LAT-1];
  assign pair      = '{tag: tagPipe[DATA_LAT-1], data: alt_data};
  assign head      = fifoMem[rdPtr];

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == CntW'(DEPTH));
  assign popFire   = !fifoEmpty && !main_busy;
`ifdef ALT_WB_BYPASS_EN
  assign bypassFire = pairValid && fifoEmpty && !main_busy;
`else
  assign bypassFire = 1'b0;
`endif
  assign pushReq  = pairValid && !bypassFire;
  // A full FIFO still accepts a pair when the head leaves in the same cycle.
  assign pushFire = pushReq && (!fifoFull || popFire);

  // Number of tags still waiting for their data.
  always_comb begin
    stageCnt = '0;
    for (int i = 0; i < DATA_LAT; i++) begin
      stageCnt = stageCnt + StgW'(validPipe[i]);
    end
  end

  // Tag delay line valid bits.
  always_ff @(posedge clk) begin
    if (rst || except) begin
      validPipe <= '0;
    end else begin
      validPipe[0] <= annValid;
      for (int i = 1; i < DATA_LAT; i++) begin
        validPipe[i] <= validPipe[i-1];
      end
    end
  end

  // Tag delay line payload; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    tagPipe[0] <= annTag;
    for (int i = 1; i < DATA_LAT; i++) begin
      tagPipe[i] <= tagPipe[i-1];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || except) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pushFire) wrPtr <= nextPtr(wrPtr);
      if (popFire)  rdPtr <= nextPtr(rdPtr);
      case ({pushFire, popFire})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (pushFire) fifoMem[wrPtr] <= pair;
  end

  // Writeback register: zero unless a pair is being presented.
  always_ff @(posedge clk) begin
    wb_en   <= 1'b0;
    wb_II   <= '0;
    wb_op   <= '0;
    wb_reg  <= '0;
    wb_wen  <= 1'b0;
    wb_data <= '0;
    if (!rst && !except) begin
      if (popFire) begin
        wb_en   <= 1'b1;
        wb_II   <= head.tag.ii;
        wb_op   <= head.tag.op;
        wb_reg  <= head.tag.rd;
        wb_wen  <= head.tag.wen;
        wb_data <= head.data;
      end else if (bypassFire) begin
        wb_en   <= 1'b1;
        wb_II   <= pair.tag.ii;
        wb_op   <= pair.tag.op;
        wb_reg  <= pair.tag.rd;
        wb_wen  <= pair.tag.wen;
        wb_data <= pair.data;
      end
    end
  end

  // Back-pressure: queued plus in-flight work approaching capacity.
  always_ff @(posedge clk) begin
    if (rst || except) begin
      pause <= 1'b0;
    end else begin
      pause <= (SumW'(count) + SumW'(stageCnt)) >= SumW'(DEPTH - 1);
    end
  end

`ifndef SYNTHESIS
  // Producer overran the FIFO; the pair is not written.
  always @(posedge clk) begin
    if (!rst && !except) begin
      assert (!(pushReq && fifoFull && !popFire))
        else $error("alt_wb_merge: pair arrived with FIFO full and no pop");
    end
  end
`endif

endmodule

// File: tb/tb_alt_wb_merge.sv
module tb_alt_wb_merge;

  localparam int unsigned LAT = 5;
  localparam int unsigned DEP = 4;
  localparam int unsigned DW  = 136;
`ifdef ALT_WB_BYPASS_EN
  localparam int WbLat = LAT + 1;
`else
  localparam int WbLat = LAT + 2;
`endif

  typedef struct packed {
    logic [9:0]    ii;
    logic [12:0]   op;
    logic [8:0]    rd;
    logic          wen;
    logic [DW-1:0] data;
  } expT;

  logic          clk = 1'b0;
  logic          rst;
  logic          except;
  logic [3:0]    alt_en;
  logic [9:0]    alt_II;
  logic [12:0]   alt_op;
  logic [8:0]    alt_reg;
  logic          alt_wen;
  logic [DW-1:0] alt_data;
  logic          main_busy;
  logic          wb_en;
  logic [9:0]    wb_II;
  logic [12:0]   wb_op;
  logic [8:0]    wb_reg;
  logic          wb_wen;
  logic [DW-1:0] wb_data;
  logic          pause;

  logic [DW-1:0] annData;
  logic [DW-1:0] dPipe [LAT];
  expT           expQ [$];
  int            nChecks = 0;
  int            nFail = 0;
  logic          monEn = 1'b0;

  alt_wb_merge #(.DATA_LAT(LAT), .DEPTH(DEP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .except(except),
    .alt_en(alt_en), .alt_II(alt_II), .alt_op(alt_op), .alt_reg(alt_reg),
    .alt_wen(alt_wen), .alt_data(alt_data), .main_busy(main_busy),
    .wb_en(wb_en), .wb_II(wb_II), .wb_op(wb_op), .wb_reg(wb_reg),
    .wb_wen(wb_wen), .wb_data(wb_data), .pause(pause)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rndData();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  // Producer-side data path: the result shows up LAT cycles after its
  // announcement; unrelated cycles carry junk.
  always @(posedge clk) begin
    dPipe[0] <= (alt_en != 4'd0) ? annData : rndData();
    for (int i = 1; i < LAT; i++) dPipe[i] <= dPipe[i-1];
  end
  assign alt_data = dPipe[LAT-1];

  // Scoreboard check at the falling edge, then advance to just after the next rise.
  task automatic step();
    expT e;
    @(negedge clk);
    if (monEn) begin
      nChecks++;
      if (wb_en === 1'b1) begin
        if (expQ.size() == 0) begin
          nFail++;
          $display("FAIL wb_unexpected: got wb_en=1 wb_II=%h wb_reg=%h, expected no writeback", wb_II, wb_reg);
        end else begin
          e = expQ.pop_front();
          if ({wb_II, wb_op, wb_reg, wb_wen, wb_data} !== e) begin
            nFail++;
            $display("FAIL wb_payload: got II=%h op=%h reg=%h wen=%b data=%h, expected II=%h op=%h reg=%h wen=%b data=%h",
                     wb_II, wb_op, wb_reg, wb_wen, wb_data, e.ii, e.op, e.rd, e.wen, e.data);
          end
        end
      end else if ({wb_en, wb_II, wb_op, wb_reg, wb_wen, wb_data} !== '0) begin
        nFail++;
        $display("FAIL wb_idle_zero: got en=%b II=%h op=%h reg=%h wen=%b, expected all zero",
                 wb_en, wb_II, wb_op, wb_reg, wb_wen);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alt_en  = 4'd0;
    alt_II  = 10'($urandom());
    alt_op  = 13'($urandom());
    alt_reg = 9'($urandom());
    alt_wen = 1'($urandom());
  endtask

  task automatic announce(input logic [3:0] en, input logic [9:0] ii, input logic [12:0] op,
                          input logic [8:0] rd, input logic wen, input logic [DW-1:0] d,
                          input logic keep);
    alt_en  = en;
    alt_II  = ii;
    alt_op  = op;
    alt_reg = rd;
    alt_wen = wen;
    annData = d;
    if (keep) expQ.push_back('{ii: ii, op: op, rd: rd, wen: wen, data: d});
  endtask

  task automatic announceRand(input logic keep);
    announce(4'($urandom_range(1, 15)), 10'($urandom()), 13'($urandom()), 9'($urandom()),
             1'($urandom()), rndData(), keep);
  endtask

  task automatic checkWb(input string name, input logic want);
    nChecks++;
    if (wb_en !== want) begin
      nFail++;
      $display("FAIL %s: got wb_en=%b, expected %b", name, wb_en, want);
    end
  endtask

  task automatic checkPause(input string name, input logic want);
    nChecks++;
    if (pause !== want) begin
      nFail++;
      $display("FAIL %s: got pause=%b, expected %b", name, pause, want);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && expQ.size() != 0; i++) step();
    nChecks++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL drain: got %0d writebacks outstanding, expected 0", expQ.size());
      expQ.delete();
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; except = 1'b0; main_busy = 1'b0; idle(); annData = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    nChecks++;
    if ({wb_en, wb_II, wb_op, wb_reg, wb_wen, wb_data, pause} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: got wb_en=%b wb_reg=%h pause=%b, expected all zero", wb_en, wb_reg, pause);
    end
    monEn = 1'b1;
    step();
  endtask

  task automatic test_single_op();
    main_busy = 1'b0;
    announce(4'b1001, 10'h3, 13'h0AB, 9'h15, 1'b1, 136'hABCD, 1'b1);
    step(); idle();
    for (int t = 1; t <= 9; t++) begin
      checkWb("single_latency", 1'(t == WbLat));
      if (t == WbLat) begin
        nChecks++;
        if (wb_reg !== 9'h15 || wb_II !== 10'h3 || wb_data !== 136'hABCD) begin
          nFail++;
          $display("FAIL single_payload: got reg=%h II=%h data=%h, expected reg=15 II=003 data=abcd",
                   wb_reg, wb_II, wb_data);
        end
      end
      step();
    end
    drain();
  endtask

  task automatic test_backpressure();
    main_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin announceRand(1'b1); step(); end
    idle();
    checkPause("bp_pause_rise", 1'b1);
    for (int c = 4; c < 9; c++) begin checkWb("bp_hold", 1'b0); step(); end
    checkPause("bp_pause_full", 1'b1);
    main_busy = 1'b0;
    for (int c = 9; c <= 14; c++) begin
      checkWb("bp_release", 1'(c >= 10 && c <= 13));
      step();
    end
    drain();
  endtask

  task automatic test_full_push_pop();
    main_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin announceRand(1'b1); step(); end
    idle();
    for (int c = 5; c < 9; c++) begin checkWb("full_hold", 1'b0); step(); end
    main_busy = 1'b0;
    for (int c = 9; c <= 16; c++) begin
      checkWb("full_pushpop", 1'(c >= 10 && c <= 14));
      step();
    end
    drain();
  endtask

  task automatic test_except();
    main_busy = 1'b0;
    announceRand(1'b0);
    step(); idle();
    step(); step();
    except = 1'b1;
    step();
    except = 1'b0;
    checkWb("except_next", 1'b0);
    step();
    announceRand(1'b1);
    step(); idle();
    for (int c = 6; c <= 14; c++) begin
      checkWb("except_after", 1'(c == 5 + WbLat));
      step();
    end
    drain();
    // Announcement coincident with the flush is discarded.
    except = 1'b1;
    announceRand(1'b0);
    step();
    except = 1'b0; idle();
    for (int c = 0; c < 12; c++) begin checkWb("except_coincident", 1'b0); step(); end
    // Queued pairs are flushed, even when the slot frees in the flush cycle.
    main_busy = 1'b1;
    announceRand(1'b0); step();
    announceRand(1'b0); step();
    idle();
    for (int c = 2; c < 8; c++) step();
    except = 1'b1; main_busy = 1'b0;
    step();
    except = 1'b0;
    for (int c = 0; c < 10; c++) begin checkWb("except_fifo_flush", 1'b0); step(); end
    drain();
  endtask

  task automatic test_reset_midop();
    main_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin announceRand(1'b0); step(); end
    idle();
    for (int c = 3; c < 7; c++) step();
    checkPause("rst_pause_before", 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    nChecks++;
    if ({wb_en, wb_II, wb_op, wb_reg, wb_wen, wb_data, pause} !== '0) begin
      nFail++;
      $display("FAIL rst_midop_outputs: got wb_en=%b wb_reg=%h pause=%b, expected all zero", wb_en, wb_reg, pause);
    end
    main_busy = 1'b0;
    for (int c = 0; c < 12; c++) begin checkWb("rst_midop_quiet", 1'b0); step(); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 120; c++) begin
      main_busy = ($urandom_range(0, 2) == 0);
      if (!pause && $urandom_range(0, 3) != 0) announceRand(1'b1);
      else idle();
      step();
    end
    idle();
    main_busy = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_full_push_pop();
    test_except();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/alt_wb_merge.md
ALT_WB_MERGE -- requirements
Module: alt_wb_merge

Interface
REQ-001 SHALL have parameters: DATA_LAT, default 5, cycles from announcement to data; DEPTH, default 4, merge FIFO entries; DATA_WIDTH, default 136, result width.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- except  in  1  pipeline flush.
- alt_en  in  4  announcement valid, any nonzero bit.
- alt_II  in  10  instruction index.
- alt_op  in  13  opcode.
- alt_reg  in  9  destination register.
- alt_wen  in  1  register write enable.
- alt_data  in  DATA_WIDTH  result, arrives DATA_LAT cycles after announcement.
- main_busy  in  1  primary writeback slot occupied this cycle.
- wb_en  out  1  merged writeback valid.
- wb_II  out  10  index.
- wb_op  out  13  opcode.
- wb_reg  out  9  destination.
- wb_wen  out  1  write enable.
- wb_data  out  DATA_WIDTH  result.
- pause  out  1  back-pressure to the producer.
REQ-003 SHALL use clk as the only clock; rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL capture {alt_II,alt_op,alt_reg,alt_wen} when alt_en!=0 into a DATA_LAT-stage tag delay line with a valid bit per stage.
REQ-005 SHALL, when the last delay stage is valid, pair its tag with the alt_data present that cycle and push the pair into the FIFO.
REQ-006 SHALL pop the FIFO head onto wb_* registered outputs in the cycle after a cycle where FIFO is nonempty and main_busy=0; wb_en SHALL be high for exactly one cycle per pop.
REQ-007 SHALL hold all wb_* fields at zero whenever wb_en=0.
REQ-008 SHALL keep the FIFO in order; pointers wrap modulo DEPTH; occupancy is a counter of width clog2(DEPTH)+1.
REQ-009 SHALL support a push and a pop in the same cycle with occupancy unchanged, including at full occupancy.
REQ-010 SHALL assert pause when (FIFO occupancy + valid delay-line stages) >= DEPTH-1, registered by one cycle.
REQ-011 SHALL never drop data: a push when full with no pop is a protocol error; the push is ignored and a simulation-only assertion fires.
REQ-012 SHALL, on except=1, clear all delay-line valid bits and the FIFO in the next cycle; wb_en SHALL be 0 in the cycle after except; an announcement coincident with except is discarded.
REQ-013 SHALL ignore alt_data in cycles when the last delay stage is not valid.

Reset
REQ-014 SHALL, in the cycle after rst=1, drive wb_en=0, all wb_* fields=0, pause=0, FIFO empty, and all delay-line valid bits=0.
REQ-015 SHALL discard in-flight announcements and FIFO contents when rst asserts mid-operation; no writeback from pre-reset ops SHALL appear afterward.

Configuration
REQ-016 Macro ALT_WB_BYPASS_EN SHALL select bypass: when defined, a pair formed with FIFO empty and main_busy=0 SHALL appear on wb_* in the next cycle without occupying a FIFO entry (latency announcement->wb_en = DATA_LAT+1); when undefined every pair enters the FIFO first (latency DATA_LAT+2).

Verification
REQ-017 Single op: alt_en=4'b1001, alt_reg=9'h15, alt_II=10'h3 at cycle 0, alt_data=136'hABCD at cycle 5, main_busy=0 -> wb_en=1, wb_reg=9'h15, wb_data=136'hABCD at cycle 7 (cycle 6 with ALT_WB_BYPASS_EN).
REQ-018 Back-pressure: main_busy=1 held, announcements on 4 consecutive cycles -> pause=1 by the third, FIFO holds 4 entries; on main_busy release -> 4 writebacks in issue order, one per cycle.
REQ-019 Simultaneous push/pop at full (occupancy 4, main_busy=0, new pair arrives) -> occupancy stays 4, no loss, order preserved.
REQ-020 except at cycle 3 after an announcement at cycle 0 -> no wb_en for that op; a new op announced at cycle 5 writes back normally.
REQ-021 rst for one cycle with 2 FIFO entries and 1 in flight -> all outputs 0 next cycle, no later wb_en for those ops.
